// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch unit.
package fetch_pkg;
  // IDLE: nothing outstanding. WAIT: response will be queued. DROP: response will be discarded.
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  localparam int unsigned PC_STEP = 2;
endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {instruction, pc} pairs with flush; pointers wrap naturally (DEPTH is a power of two).
module fetch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [2*WIDTH-1:0]     i_data,
  output logic [2*WIDTH-1:0]     o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr, r_rd;
  logic [CW-1:0]      r_cnt;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
endmodule

// File: rtl/fetch_queue.sv
// Fetch unit: one outstanding memory request, decoupling queue to decode, redirect/halt, sticky error.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             memReq,
  output logic [WIDTH-1:0] memAddr,
  input  logic             memAck,
  input  logic             memDone,
  input  logic [WIDTH-1:0] memData,
  output logic [WIDTH-1:0] instruction,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] incPC,
  output logic             instrValid,
  input  logic             instrReady,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirectPC,
  input  logic             halt,
  output logic             err
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t             r_state, w_state_nx;
  logic [WIDTH-1:0]   r_fetch_pc, r_tag;
  logic               r_err;
  logic [WIDTH:0]     w_pc_sum;
  logic [CW-1:0]      w_count;
  logic               w_full, w_empty, w_push, w_pop, w_room, w_accept;
  logic [2*WIDTH-1:0] w_head;

  // Redirect wins over both queue ports; reset hides the head from decode.
  assign instrValid = ~rst & ~w_empty;
  assign w_pop      = instrValid & instrReady & ~redirect;
  assign w_push     = (r_state == WAIT) & memDone & ~redirect;
  // Room after this cycle's push: count+1-pop < DEPTH, rewritten without the subtraction.
  assign w_room     = w_pop | (w_count < CW'(DEPTH - 1));
  assign w_accept   = memReq & memAck;
  assign w_pc_sum   = {1'b0, r_fetch_pc} + (WIDTH+1)'(PC_STEP);

  // Next state and request strobe; defaults first, reset forces the request low.
  always_comb begin
    w_state_nx = r_state;
    memReq     = 1'b0;
    case (r_state)
      IDLE: begin
        memReq = ~halt & ~redirect & ~w_full;
        if (memReq && memAck) w_state_nx = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          w_state_nx = memDone ? IDLE : DROP;
        end else if (memDone) begin
          memReq     = ~halt & w_room;
          w_state_nx = (memReq && memAck) ? WAIT : IDLE;
        end
      end
      DROP: if (memDone) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
    if (rst) memReq = 1'b0;
  end

  // State, fetch address, in-flight tag and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_tag      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (redirect) begin
        r_fetch_pc <= {redirectPC[WIDTH-1:1], 1'b0};
        if (redirectPC[0]) r_err <= 1'b1;
      end else if (w_accept) begin
        r_fetch_pc <= w_pc_sum[WIDTH-1:0];
        r_tag      <= r_fetch_pc;
        if (w_pc_sum[WIDTH]) r_err <= 1'b1;
      end
    end
  end

  fetch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_data  ({memData, r_tag}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign memAddr     = r_fetch_pc;
  assign instruction = w_head[2*WIDTH-1:WIDTH];
  assign pc          = w_head[WIDTH-1:0];
  assign incPC       = pc + WIDTH'(PC_STEP);
  assign err         = r_err;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table, directed corner sequences, randomized run against a queue-level model.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memReq, memAck, memDone, instrValid, instrReady, redirect, halt, err;
  logic [15:0] memAddr, memData, instruction, pc, incPC, redirectPC;

  int n_chk = 0;
  int n_err = 0;

  fetch_queue #(.WIDTH(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .memReq(memReq), .memAddr(memAddr), .memAck(memAck),
    .memDone(memDone), .memData(memData), .instruction(instruction), .pc(pc),
    .incPC(incPC), .instrValid(instrValid), .instrReady(instrReady),
    .redirect(redirect), .redirectPC(redirectPC), .halt(halt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before sampling.
  task automatic drive(input logic ack, input logic done, input logic [15:0] data,
                       input logic rdy, input logic redir, input logic [15:0] rpc,
                       input logic hlt);
    @(negedge clk);
    rst = 1'b0; memAck = ack; memDone = done; memData = data; instrReady = rdy;
    redirect = redir; redirectPC = rpc; halt = hlt;
    #1;
  endtask

  // Two reset edges; outputs must stay quiet while rst is high.
  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst = 1'b1; memAck = 1'b0; memDone = 1'b0; memData = '0; instrReady = 1'b0;
      redirect = 1'b0; redirectPC = '0; halt = 1'b0;
      #1;
      chk1("rst_memReq", memReq, 1'b0);
      chk1("rst_instrValid", instrValid, 1'b0);
    end
  endtask

  // Head checks: data is 16'h1000+address by construction of every memory stimulus here.
  task automatic chk_head(input string nm, input logic [15:0] exp_pc);
    chk1({nm, "_valid"}, instrValid, 1'b1);
    chk16({nm, "_pc"}, pc, exp_pc);
    chk16({nm, "_instr"}, instruction, 16'h1000 + exp_pc);
    chk16({nm, "_incPC"}, incPC, exp_pc + 16'd2);
  endtask

  typedef struct {
    logic ack; logic done; logic [15:0] data; logic rdy; logic redir; logic [15:0] rpc;
    logic e_req; logic [15:0] e_addr; logic e_vld; logic [15:0] e_pc; logic e_err;
  } vec_t;

  vec_t tbl [9];

  initial begin
    // 1-cycle memory, decode always ready, then a misaligned redirect.
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 16'h1000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 16'h1002, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0000, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 16'h1004, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h0002, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 16'h1006, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 16'h0004, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 16'h0006, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b0, 16'h0000, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0013, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0012, 1'b0, 16'h0000, 1'b1};

    memAck = 1'b0; memDone = 1'b0; memData = '0; instrReady = 1'b0;
    redirect = 1'b0; redirectPC = '0; halt = 1'b0;

    // ---------------- table vectors ----------------
    do_reset();
    chk1("rst_err", err, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].ack, tbl[i].done, tbl[i].data, tbl[i].rdy, tbl[i].redir, tbl[i].rpc, 1'b0);
      chk1($sformatf("tbl%0d_memReq", i), memReq, tbl[i].e_req);
      if (tbl[i].e_req) chk16($sformatf("tbl%0d_memAddr", i), memAddr, tbl[i].e_addr);
      chk1($sformatf("tbl%0d_valid", i), instrValid, tbl[i].e_vld);
      if (tbl[i].e_vld) chk_head($sformatf("tbl%0d", i), tbl[i].e_pc);
      chk1($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
    end

    // ---------------- full queue, decode stalled ----------------
    do_reset();
    begin
      int acc;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
        logic [15:0] a;
        a = 16'h1000 + 16'(2 * (c - 1));
        drive(1'b1, (c >= 1 && c <= 4), a, 1'b0, 1'b0, 16'h0, 1'b0);
        if (memReq && memAck) acc++;
      end
      chk16("full_accepts", 16'(acc), 16'd4);
      chk1("full_memReq_low", memReq, 1'b0);
      chk_head("full_hold", 16'h0000);
      drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);   // pop
      chk1("full_memReq_low2", memReq, 1'b0);
      chk_head("full_hold2", 16'h0000);
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk1("full_resume", memReq, 1'b1);
      chk16("full_resume_addr", memAddr, 16'h0008);
      chk_head("full_next", 16'h0002);
    end

    // ---------------- redirect during 3-cycle latency -> DROP ----------------
    do_reset();
    drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 1'b0);
    chk1("drop_redir_req", memReq, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk1("drop_wait_req", memReq, 1'b0);
    drive(1'b1, 1'b1, 16'h1000, 1'b1, 1'b0, 16'h0, 1'b0);
    chk1("drop_done_req", memReq, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk1("drop_new_req", memReq, 1'b1);
    chk16("drop_new_addr", memAddr, 16'h0040);
    chk1("drop_no_stale", instrValid, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk1("drop_wait_valid", instrValid, 1'b0);
    drive(1'b0, 1'b1, 16'h1040, 1'b1, 1'b0, 16'h0, 1'b0);
    chk1("drop_resp_valid", instrValid, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk_head("drop_head", 16'h0040);

    // ---------------- redirect with memDone and pop ----------------
    do_reset();
    drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    drive(1'b1, 1'b1, 16'h1000, 1'b1, 1'b0, 16'h0, 1'b0);
    drive(1'b1, 1'b1, 16'h1002, 1'b1, 1'b1, 16'h0080, 1'b0);
    chk1("rdp_req", memReq, 1'b0);
    chk_head("rdp_head", 16'h0000);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk1("rdp_empty", instrValid, 1'b0);
    chk1("rdp_idle_req", memReq, 1'b1);
    chk16("rdp_addr", memAddr, 16'h0080);

    // ---------------- halt with request outstanding ----------------
    do_reset();
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk1("halt_req0", memReq, 1'b0);
    drive(1'b1, 1'b1, 16'h1000, 1'b0, 1'b0, 16'h0, 1'b1);
    chk1("halt_req1", memReq, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk1("halt_req2", memReq, 1'b0);
    chk_head("halt_head", 16'h0000);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk1("halt_resume", memReq, 1'b1);
    chk16("halt_resume_addr", memAddr, 16'h0002);

    // ---------------- address wrap sets err ----------------
    do_reset();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    chk1("wrap_err0", err, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk16("wrap_addr", memAddr, 16'hFFFE);
    chk1("wrap_err1", err, 1'b0);
    drive(1'b0, 1'b1, 16'h0FFE, 1'b0, 1'b0, 16'h0, 1'b0);
    chk1("wrap_err2", err, 1'b1);
    chk16("wrap_next_addr", memAddr, 16'h0000);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk1("wrap_valid", instrValid, 1'b1);
    chk16("wrap_pc", pc, 16'hFFFE);
    chk16("wrap_incPC", incPC, 16'h0000);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk1("wrap_err_sticky", err, 1'b1);
    do_reset();
    chk1("wrap_err_cleared", err, 1'b0);

    // ---------------- reset mid-request, stray memDone ignored ----------------
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b1, 1'b1, 16'h1000, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1; memDone = 1'b0; memAck = 1'b1;
    #1;
    chk1("midrst_req", memReq, 1'b0);
    chk1("midrst_valid", instrValid, 1'b0);
    drive(1'b0, 1'b1, 16'h1002, 1'b0, 1'b0, 16'h0, 1'b0);
    chk1("stray_req", memReq, 1'b1);
    chk16("stray_addr", memAddr, 16'h0000);
    chk1("stray_valid0", instrValid, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk1("stray_valid1", instrValid, 1'b0);

    // ---------------- randomized run against queue-level model ----------------
    do_reset();
    begin
      logic        pend, pdrop;
      int          rem, qn, pops;
      logic [15:0] paddr, exp_fetch, exp_cons;
      pend = 1'b0; pdrop = 1'b0; rem = 0; qn = 0; pops = 0;
      paddr = '0; exp_fetch = 16'h0000; exp_cons = 16'h0000;
      for (int i = 0; i < 3000; i++) begin
        logic a, d, rd, r, h, acc, pop, push;
        logic [15:0] rp;
        d  = pend && (rem == 1);
        a  = ($urandom_range(0, 9) < 7);
        rd = ($urandom_range(0, 9) < 7);
        h  = ($urandom_range(0, 9) == 0);
        r  = ($urandom_range(0, 31) == 0);
        rp = 16'($urandom_range(0, 16'h3FFF) * 2);
        drive(a, d, 16'h1000 + paddr, rd, r, rp, h);
        acc  = memReq & a;
        pop  = instrValid & rd & ~r;
        push = d & ~pdrop & ~r;
        chk1("rand_valid", instrValid, (qn != 0));
        if (h || r) chk1("rand_req_blocked", memReq, 1'b0);
        if (pend && !d) chk1("rand_one_outstanding", memReq, 1'b0);
        if (memReq) begin
          chk16("rand_addr", memAddr, exp_fetch);
          chk1("rand_room", (qn + int'(push) - int'(pop)) < DEPTH, 1'b1);
        end
        if (pop) begin
          chk16("rand_pc", pc, exp_cons);
          chk16("rand_instr", instruction, 16'h1000 + exp_cons);
          chk16("rand_incPC", incPC, exp_cons + 16'd2);
          exp_cons = exp_cons + 16'd2;
          pops++;
        end
        // model state after the coming edge
        if (d) begin
          pend = 1'b0; pdrop = 1'b0;
        end else if (pend) begin
          rem--;
          if (r) pdrop = 1'b1;
        end
        if (acc) begin
          pend = 1'b1; pdrop = 1'b0; rem = $urandom_range(1, 3);
          paddr = exp_fetch;
          exp_fetch = exp_fetch + 16'd2;
        end
        if (r) begin
          qn = 0; exp_fetch = rp; exp_cons = rp;
        end else begin
          qn = qn + int'(push) - int'(pop);
        end
      end
      chk1("rand_progress", pops > 200, 1'b1);
      chk1("rand_err_clear", err, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised fetch unit with a decoupling instruction queue, sitting between the PC/instruction-memory side and decode. Issues one instruction-memory request at a time to a variable-latency memory, buffers returned instructions with their PCs in a DEPTH-entry queue, and presents them to decode under a valid/ready handshake. Supports branch redirect with queue flush and in-flight-response discard, a halt input that stops new fetches, and a sticky error flag.

## Interface
- WIDTH, 16: instruction and address width.
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 0: fetch address after reset; must be even.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- memReq  out  1  request valid to instruction memory.
- memAddr  out  WIDTH  request address; equals fetchPC.
- memAck  in  1  memory accepts request this cycle.
- memDone  in  1  response valid; at most one per accepted request, never in the accept cycle.
- memData  in  WIDTH  response instruction, valid with memDone.
- instruction  out  WIDTH  queue-head instruction.
- pc  out  WIDTH  queue-head PC.
- incPC  out  WIDTH  pc + 2, modulo 2^WIDTH.
- instrValid  out  1  queue non-empty.
- instrReady  in  1  decode consumes head when instrValid & instrReady.
- redirect  in  1  branch resolved taken; load redirectPC.
- redirectPC  in  WIDTH  new fetch address.
- halt  in  1  level; no new requests while high.
- err  out  1  sticky error.

## Operation
- States: IDLE (no outstanding request), WAIT (request outstanding, response kept), DROP (request outstanding, response discarded).
- IDLE: memReq = ~halt & ~redirect & (count < DEPTH). On memReq & memAck: fetchPC += 2, tag register <= old fetchPC, go WAIT.
- WAIT, memDone & ~redirect: push {memData, tag} into queue. In the same cycle memReq = ~halt & (count + 1 - pop < DEPTH); if accepted, stay WAIT with new tag, else go IDLE.
- Redirect (any state): flush queue (count <= 0), fetchPC <= redirectPC, memReq forced low. WAIT without memDone -> DROP; WAIT with memDone -> IDLE, response dropped; IDLE -> IDLE. Redirect overrides pop and push in the same cycle.
- DROP: memReq low; on memDone discard data, go IDLE. A further redirect in DROP only updates fetchPC.
- Pop: instrValid & instrReady removes the head; pop and push in one cycle keep count unchanged.
- Halt: stops new requests only; an outstanding response still completes and is queued; the queue keeps draining to decode.
- err set when fetchPC increment wraps past 2^WIDTH-2, or on redirect with redirectPC[0] = 1 (fetchPC still loaded, bit 0 cleared). Cleared only by rst.
- Arithmetic unsigned, modulo 2^WIDTH; count is log2(DEPTH)+1 bits.

## Timing
- Reset (rst high at an edge): state IDLE, count 0, fetchPC = RESET_PC, err 0. While rst is high memReq = 0 and instrValid = 0. Reset mid-request abandons it; a later stray memDone in IDLE is ignored.
- First memReq in the first cycle after rst falls, memAddr = RESET_PC.
- Latency: response at edge N appears on instruction/instrValid after that edge (one cycle of queue latency).
- Peak throughput: one instruction per cycle with 1-cycle memory and decode ready.
- Full: count = DEPTH and IDLE -> memReq low; resumes the cycle after a pop.
- instruction, pc, incPC are held stable while instrValid & ~instrReady.

## Structure
- Package fetch_pkg: state enum (IDLE, WAIT, DROP), PC_STEP = 2 constant.
- Sub-module fetch_fifo: DEPTH x 2*WIDTH circular buffer with push, pop, flush, count, full and empty; wrap-around pointers.
- Top: FSM, fetchPC/tag registers, err logic.

## Test plan
- Reset, 1-cycle memory returning 16'h1000+addr, instrReady = 1 -> pc 0,2,4,6 on consecutive cycles, incPC = pc+2, memAddr first = 0.
- instrReady = 0, DEPTH = 4 -> exactly 4 accepts, memReq low with count = 4; one pop -> memReq high next cycle, addr 8.
- 3-cycle memory latency, redirect to 16'h0040 one cycle after accept -> DROP, stale response discarded, next memAddr = 0040, instrValid 0 until its response.
- Redirect in same cycle as memDone and pop -> queue empty next cycle, state IDLE, memAddr = redirectPC.
- halt high with request outstanding -> response queued, no further memReq; halt low -> fetch resumes at next PC.
- Redirect to 16'hFFFE, then fetch -> err = 1 after wrap, stays 1 until rst; redirect to 16'h0013 -> err = 1, memAddr = 0012.
